// File: rtl/ireg_wb_sched_pkg.sv
// ireg_pkg: shared register-index and data types for the integer writeback path
package ireg_pkg;
    typedef logic [4:0] reg_idx_t;
    typedef logic signed [31:0] xlen_t;
    localparam reg_idx_t ZERO_REG = 5'd0;
endpackage

// File: rtl/ireg_wb_sched_scoreboard.sv
// ireg_scoreboard: pending-write vector, long-op count and RAW/WAW hazard compare
// IREG_SB_BYPASS_EN lets a return accepted this cycle unmask its register immediately
import ireg_pkg::*;

module ireg_scoreboard #(
    parameter int MAX_LONG = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t rs1,
    input  logic     rs1_v,
    input  reg_idx_t rs2,
    input  logic     rs2_v,
    input  reg_idx_t rd,
    input  logic     rd_v,
    input  logic     set,
    input  reg_idx_t set_rd,
    input  logic     clr,
    input  reg_idx_t clr_rd,
    output logic     hazard,
    output logic     full
);
    logic [31:0] pending, set_m, clr_m, vis;
    logic [3:0]  out_cnt;
    logic        inc, dec;
    always_comb begin
        set_m = (set && set_rd != ZERO_REG) ? 32'd1 << set_rd : '0;
        clr_m = clr ? 32'd1 << clr_rd : '0;
`ifdef IREG_SB_BYPASS_EN
        vis = pending & ~clr_m;
`else
        vis = pending;
`endif
        hazard = (rs1_v & vis[rs1]) | (rs2_v & vis[rs2]) | (rd_v & vis[rd]);
        full = out_cnt == 4'(MAX_LONG);
        inc = |set_m;
        dec = clr & (inc | (out_cnt != 4'd0));
    end
    // clear is applied before set so a same-register reissue stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            out_cnt <= '0;
        end else begin
            pending <= ((pending & ~clr_m) | set_m) & ~32'd1;
            out_cnt <= out_cnt + 4'(inc) - 4'(dec);
        end
    end
endmodule

// File: rtl/ireg_wb_sched.sv
// ireg_wb_sched: single-port register-file writeback arbiter with long-latency scoreboard
// Build option IREG_SB_BYPASS_EN: same-cycle scoreboard clear on return acceptance
import ireg_pkg::*;

module ireg_wb_sched #(
    parameter int MAX_LONG   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     issue_v,
    input  reg_idx_t issue_rs1,
    input  logic     issue_rs1_v,
    input  reg_idx_t issue_rs2,
    input  logic     issue_rs2_v,
    input  reg_idx_t issue_rd,
    input  logic     issue_rd_v,
    input  logic     issue_long,
    output logic     stall,
    input  logic     x_v,
    input  reg_idx_t x_rd,
    input  xlen_t    x_data,
    input  logic     lret_v,
    output logic     lret_ready,
    input  reg_idx_t lret_rd,
    input  xlen_t    lret_data,
    output logic     wb_v,
    output reg_idx_t wb_rd,
    output xlen_t    wb_data
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic          hazard, full, accept, x_w, fire, starved;
    logic [SW-1:0] starve_cnt;
    always_comb begin
        lret_ready = ~x_v | (x_rd == ZERO_REG);
        accept = lret_v & lret_ready;
        x_w = x_v & (x_rd != ZERO_REG);
        starved = starve_cnt == SW'(STARVE_MAX);
        stall = issue_v & (hazard | (issue_long & full) | starved);
        fire = issue_v & ~stall;
    end
    ireg_scoreboard #(.MAX_LONG(MAX_LONG)) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .rs1    (issue_rs1),
        .rs1_v  (issue_rs1_v),
        .rs2    (issue_rs2),
        .rs2_v  (issue_rs2_v),
        .rd     (issue_rd),
        .rd_v   (issue_rd_v),
        .set    (fire & issue_long & issue_rd_v),
        .set_rd (issue_rd),
        .clr    (accept),
        .clr_rd (lret_rd),
        .hazard (hazard),
        .full   (full)
    );
    // an x0 execute result yields the port, so the long return takes it instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wb_v       <= 1'b0;
            wb_rd      <= ZERO_REG;
            wb_data    <= '0;
        end else begin
            starve_cnt <= (lret_v & ~lret_ready) ? (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
            wb_v       <= x_w | (accept & (lret_rd != ZERO_REG));
            wb_rd      <= x_w ? x_rd : lret_rd;
            wb_data    <= x_w ? x_data : lret_data;
        end
    end
endmodule

// File: tb/tb_ireg_wb_sched.sv
// tb_ireg_wb_sched: directed plus random checks of ireg_wb_sched against a queue-based model
module tb_ireg_wb_sched;
`ifdef IREG_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, rst_n;
    logic        issue_v, issue_rs1_v, issue_rs2_v, issue_rd_v, issue_long;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, x_rd, lret_rd, wb_rd;
    logic        x_v, lret_v, stall, lret_ready, wb_v;
    logic signed [31:0] x_data, lret_data, wb_data;

    int checks = 0, errors = 0;
    int q[$];
    int cnt, st;
    bit m_rdy, m_acc, m_stall, e_v;
    logic [4:0]  e_rd;
    logic [31:0] e_d;

    always #5 clk = ~clk;

    ireg_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .issue_v(issue_v), .issue_rs1(issue_rs1), .issue_rs1_v(issue_rs1_v),
        .issue_rs2(issue_rs2), .issue_rs2_v(issue_rs2_v), .issue_rd(issue_rd),
        .issue_rd_v(issue_rd_v), .issue_long(issue_long), .stall(stall),
        .x_v(x_v), .x_rd(x_rd), .x_data(x_data),
        .lret_v(lret_v), .lret_ready(lret_ready), .lret_rd(lret_rd), .lret_data(lret_data),
        .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit pend(input int r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pv(input int r);
        return pend(r) && !(BYP && m_acc && r == int'(lret_rd));
    endfunction

    task automatic model_reset();
        q.delete();
        cnt = 0;
        st = 0;
        e_v = 1'b0;
    endtask

    task automatic idle();
        issue_v = 0; issue_rs1 = 0; issue_rs1_v = 0; issue_rs2 = 0; issue_rs2_v = 0;
        issue_rd = 0; issue_rd_v = 0; issue_long = 0;
        x_v = 0; x_rd = 0; x_data = 0; lret_v = 0; lret_rd = 0; lret_data = 0;
    endtask

    task automatic iss(input bit v, input int r1, input bit r1v, input int r2, input bit r2v,
                       input int d, input bit dv, input bit lg);
        issue_v = v; issue_rs1 = 5'(r1); issue_rs1_v = r1v; issue_rs2 = 5'(r2);
        issue_rs2_v = r2v; issue_rd = 5'(d); issue_rd_v = dv; issue_long = lg;
    endtask

    // one clock: check combinational outputs, advance the model, check writeback
    task automatic cyc();
        bit fire, set;
        #1;
        m_rdy = !x_v || x_rd == 5'd0;
        m_acc = lret_v && m_rdy;
        m_stall = issue_v && ((issue_rs1_v && pv(issue_rs1)) || (issue_rs2_v && pv(issue_rs2)) ||
                  (issue_rd_v && pv(issue_rd)) || (issue_long && cnt == 4) || st == 8);
        chk("stall", 32'(stall), 32'(m_stall));
        chk("lret_ready", 32'(lret_ready), 32'(m_rdy));
        fire = issue_v && !m_stall;
        set = fire && issue_long && issue_rd_v && issue_rd != 5'd0;
        if (x_v && x_rd != 5'd0) begin
            e_v = 1; e_rd = x_rd; e_d = x_data;
        end else if (m_acc && lret_rd != 5'd0) begin
            e_v = 1; e_rd = lret_rd; e_d = lret_data;
        end else e_v = 0;
        if (m_acc)
            for (int i = 0; i < q.size(); i++)
                if (q[i] == int'(lret_rd)) begin q.delete(i); break; end
        if (set) begin q.push_back(int'(issue_rd)); cnt++; end
        if (m_acc && cnt > 0) cnt--;
        st = (lret_v && !m_rdy) ? (st < 8 ? st + 1 : 8) : 0;
        @(posedge clk);
        #1;
        chk("wb_v", 32'(wb_v), 32'(e_v));
        if (e_v) begin
            chk("wb_rd", 32'(wb_rd), 32'(e_rd));
            chk("wb_data", wb_data, e_d);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        #12;
        chk("rst_wb_v", 32'(wb_v), 0);
        chk("rst_lret_ready", 32'(lret_ready), 1);
        iss(1, 5, 1, 6, 1, 7, 1, 1);
        #1 chk("rst_stall", 32'(stall), 0);
        idle();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        cyc();

        // RAW on a long result
        iss(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        iss(1, 5, 1, 0, 0, 9, 1, 0);
        repeat (3) cyc();
        chk("raw_hold", 32'(stall), 1);
        lret_v = 1; lret_rd = 5; lret_data = 32'hdead0005; cyc();
        chk("raw_release", 32'(stall), 0);
        lret_v = 0; cyc();
        idle(); cyc();

        // execute beats long return for the single port
        iss(1, 0, 0, 0, 0, 7, 1, 1); cyc();
        idle();
        x_v = 1; x_rd = 3; x_data = 32'h11; lret_v = 1; lret_rd = 7; lret_data = 32'h22; cyc();
        chk("arb_x_rd", 32'(wb_rd), 3);
        chk("arb_x_data", wb_data, 32'h11);
        x_v = 0; cyc();
        chk("arb_l_rd", 32'(wb_rd), 7);
        chk("arb_l_data", wb_data, 32'h22);
        idle(); cyc();

        // capacity limit
        for (int r = 8; r < 12; r++) begin iss(1, 0, 0, 0, 0, r, 1, 1); cyc(); end
        iss(1, 0, 0, 0, 0, 12, 1, 1); cyc();
        chk("full_stall", 32'(stall), 1);
        iss(1, 0, 0, 0, 0, 13, 1, 0); cyc();
        iss(1, 0, 0, 0, 0, 12, 1, 1); lret_v = 1; lret_rd = 8; lret_data = 32'h8; cyc();
        chk("full_release", 32'(stall), 0);
        idle();
        for (int r = 9; r < 13; r++) begin lret_v = 1; lret_rd = 5'(r); lret_data = r; cyc(); end
        idle(); cyc();

        // starvation of a long return
        iss(1, 0, 0, 0, 0, 20, 1, 1); cyc();
        iss(1, 2, 1, 0, 0, 0, 0, 0);
        x_v = 1; x_rd = 1; lret_v = 1; lret_rd = 20; lret_data = 32'h2020;
        for (int i = 0; i < 8; i++) begin x_data = i; cyc(); end
        chk("starve_stall", 32'(stall), 1);
        x_v = 0; cyc();
        chk("starve_clear", 32'(stall), 0);
        idle(); cyc();

        // x0 destinations
        iss(1, 0, 0, 0, 0, 0, 1, 1); x_v = 1; x_rd = 0; x_data = 32'h55; cyc();
        chk("x0_wb_v", 32'(wb_v), 0);
        idle();
        for (int r = 1; r < 5; r++) begin iss(1, 0, 0, 0, 0, r, 1, 1); cyc(); end
        idle();
        for (int r = 1; r < 5; r++) begin lret_v = 1; lret_rd = 5'(r); lret_data = -r; cyc(); end
        idle(); cyc();

        // asynchronous reset mid-traffic
        iss(1, 0, 0, 0, 0, 6, 1, 1); cyc();
        idle(); x_v = 1; x_rd = 2; x_data = 32'h77; cyc();
        #1 rst_n = 0;
        #1 chk("arst_wb_v", 32'(wb_v), 0);
        iss(1, 6, 1, 0, 0, 0, 0, 0); x_v = 0;
        #1 chk("arst_pending", 32'(stall), 0);
        idle();
        model_reset();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            iss($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            x_v = $urandom_range(0, 2) == 0;
            x_rd = 5'($urandom_range(0, 7));
            x_data = $urandom;
            lret_v = q.size() > 0 && $urandom_range(0, 1) == 1;
            lret_rd = lret_v ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'd0;
            lret_data = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
